// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;
   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

   localparam int SLOT_MAX = 32;
   localparam int CNT_OVF  = 33;

   // Left shift that MSB-aligns an n-bit word held in the low bits of a 32-bit register.
   function automatic logic [5:0] align_shift(input logic [5:0] n);
      return (n >= 6'(SLOT_MAX)) ? 6'd0 : 6'(SLOT_MAX) - n;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/i2s_rx.sv
// Oversampling I2S receiver: slot-length detection, lock tracking and
// parallel stereo sample output in the master-clock domain.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int MIN_SLOT     = 8,
   parameter int TIMEOUT      = 1024
) (
   input  logic                    i_clk,
   input  logic                    reset_n,
   input  logic                    i_bck,
   input  logic                    i_ws,
   input  logic                    i_data,
   output logic [SAMPLE_WIDTH-1:0] o_left,
   output logic [SAMPLE_WIDTH-1:0] o_right,
   output logic                    o_valid,
   output logic                    o_locked,
   output logic [5:0]              o_slot_len,
   output logic                    o_err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic bck_s, ws_s, data_s;

   sync_2ff #(.WIDTH(3)) u_sync (
      .clk     (i_clk),
      .reset_n (reset_n),
      .d       ({i_bck, i_ws, i_data}),
      .q       ({bck_s, ws_s, data_s})
   );

   // Registered edge detect; ws/data are captured alongside the rise.
   logic bck_d, rise, ws_r, data_r;

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         bck_d  <= 1'b0;
         rise   <= 1'b0;
         ws_r   <= 1'b0;
         data_r <= 1'b0;
      end else begin
         bck_d  <= bck_s;
         rise   <= bck_s & ~bck_d;
         ws_r   <= ws_s;
         data_r <= data_s;
      end
   end

   // Bit 31 of the history is never needed again, so only 31 bits are kept.
   logic [30:0]             shreg;
   logic [31:0]             shnew, aligned;
   logic [5:0]              bitcnt, n, nl, nr;
   logic                    ws_prev, ws_seen, frame_done;
   logic [SAMPLE_WIDTH-1:0] sample, left_w, right_w;

   assign shnew   = {shreg, data_r};
   assign n       = (bitcnt == 6'(CNT_OVF)) ? 6'(CNT_OVF) : bitcnt + 6'd1;
   assign aligned = shnew << align_shift(n);
   assign sample  = SAMPLE_WIDTH'(aligned >> (32 - SAMPLE_WIDTH));

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg      <= '0;
         bitcnt     <= '0;
         ws_prev    <= 1'b0;
         ws_seen    <= 1'b0;
         nl         <= '0;
         nr         <= '0;
         left_w     <= '0;
         right_w    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (rise) begin
            shreg   <= shnew[30:0];
            ws_prev <= ws_r;
            ws_seen <= 1'b1;
            // The bit under a changed WS is the LSB of the word that just ended.
            if (ws_seen && (ws_r != ws_prev)) begin
               bitcnt <= '0;
               if (ws_r) begin
                  left_w <= sample;
                  nl     <= n;
               end else begin
                  right_w    <= sample;
                  nr         <= n;
                  frame_done <= 1'b1;
               end
            end else if (bitcnt != 6'(CNT_OVF)) begin
               bitcnt <= bitcnt + 6'd1;
            end
         end
      end
   end

   logic [TW-1:0] idle;
   logic          timeout;

   assign timeout = (idle == TW'(TIMEOUT));

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n)      idle <= '0;
      else if (rise)     idle <= '0;
      else if (!timeout) idle <= idle + TW'(1);
   end

   state_t     state, nxt;
   logic [5:0] ref_len;
   logic       legal, good, upd, frame_err;

   assign legal = (nl == nr) && (nr >= 6'(MIN_SLOT)) && (nr <= 6'(SLOT_MAX));
   assign good  = legal && (nr == ref_len);

   always_comb begin
      nxt       = state;
      upd       = 1'b0;
      frame_err = 1'b0;
      if (timeout) begin
         nxt       = UNLOCKED;
         frame_err = (state == LOCKED);
      end else if (frame_done) begin
         case (state)
            UNLOCKED: if (legal) nxt = ACQUIRE;
            ACQUIRE: begin
               if (good) begin
                  nxt = LOCKED;
                  upd = 1'b1;
               end else begin
                  nxt = UNLOCKED;
               end
            end
            LOCKED: begin
               if (good) begin
                  upd = 1'b1;
               end else begin
                  nxt       = UNLOCKED;
                  frame_err = 1'b1;
               end
            end
            default: nxt = UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= UNLOCKED;
         ref_len    <= '0;
         o_left     <= '0;
         o_right    <= '0;
         o_valid    <= 1'b0;
         o_err      <= 1'b0;
         o_slot_len <= '0;
      end else begin
         state   <= nxt;
         o_valid <= upd;
         o_err   <= frame_err;
         if (frame_done && !timeout) begin
            ref_len    <= nr;
            o_slot_len <= nr;
         end
         if (upd) begin
            o_left  <= left_w;
            o_right <= right_w;
         end
      end
   end

   assign o_locked = (state == LOCKED);
endmodule

// File: tb/tb_i2s_rx.sv
// Randomized bench for i2s_rx with a frame-level reference model and per-cycle compare.
module tb_i2s_rx;
   localparam int SW       = 16;
   localparam int MIN_SLOT = 8;
   localparam int TIMEOUT  = 1024;
   localparam int MAXC     = 60000;

   logic        i_clk = 1'b0, reset_n = 1'b0;
   logic        i_bck = 1'b0, i_ws = 1'b0, i_data = 1'b0;
   logic [SW-1:0] o_left, o_right;
   logic        o_valid, o_locked, o_err;
   logic [5:0]  o_slot_len;

   i2s_rx #(.SAMPLE_WIDTH(SW), .MIN_SLOT(MIN_SLOT), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(i_clk), .reset_n(reset_n), .i_bck(i_bck), .i_ws(i_ws), .i_data(i_data),
      .o_left(o_left), .o_right(o_right), .o_valid(o_valid), .o_locked(o_locked),
      .o_slot_len(o_slot_len), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      bit          has, valid, err, lock;
      int          slot;
      logic [15:0] left, right;
   } ev_t;

   ev_t ev [MAXC];
   int  errors = 0, checks = 0;
   bit  chk_on = 0, loose = 0;
   int  last_hi = 0;

   // Frame-level model state
   int          m_state = 0, m_ref = 0;
   logic [15:0] m_left = 0, m_right = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] samp(input logic [31:0] v, input int n);
      if (n >= 16) return 16'(v >> (n - 16));
      else         return 16'(v << (16 - n));
   endfunction

   function automatic logic [31:0] mask(input int n);
      logic [63:0] one;
      one = 64'd1;
      return 32'((one << n) - 64'd1);
   endfunction

   // A completed frame (nl, nr) decides state, outputs and error at cycle t.
   task automatic model_frame(input int nl, input int nr, input logic [31:0] l, input logic [31:0] r, input int t);
      bit legal, good, v, e;
      legal = (nl == nr) && (nr >= MIN_SLOT) && (nr <= 32);
      good  = legal && (nr == m_ref);
      v = 0; e = 0;
      case (m_state)
         0: if (legal) m_state = 1;
         1: if (good) begin m_state = 2; v = 1; end else m_state = 0;
         default: if (good) v = 1; else begin m_state = 0; e = 1; end
      endcase
      m_ref = nr;
      if (v) begin m_left = samp(l, nl); m_right = samp(r, nr); end
      if (t < MAXC) begin
         ev[t].has = 1; ev[t].valid = v; ev[t].err = e; ev[t].lock = (m_state == 2);
         ev[t].slot = nr; ev[t].left = m_left; ev[t].right = m_right;
      end
   endtask

   // One BCK period of 8 i_clk cycles; hi is the cycle count when BCK goes high.
   task automatic drive_bit(input logic w, input logic d, output int hi);
      @(negedge i_clk);
      i_bck = 1'b0; i_ws = w; i_data = d;
      repeat (4) @(negedge i_clk);
      i_bck = 1'b1;
      hi = cyc;
      repeat (3) @(negedge i_clk);
   endtask

   task automatic send_frame(input int nl, input int nr, input logic [31:0] l, input logic [31:0] r);
      int hi;
      logic d, w;
      hi = 0;
      for (int i = 0; i < nl + nr; i++) begin
         d = (i < nl) ? l[nl-1-i] : r[nr-1-(i-nl)];
         w = (i >= nl - 1) && (i <= nl + nr - 2);
         drive_bit(w, d, hi);
      end
      last_hi = hi;
      // 2 sync + edge + shift + output register after the first sampling edge (hi+1)
      model_frame(nl, nr, l, r, hi + 5);
   endtask

   task automatic settle();
      repeat (8) @(negedge i_clk);
   endtask

   // Per-cycle comparison against the model's scheduled events
   bit          e_v, e_e, e_lk = 0;
   int          e_sl = 0;
   logic [15:0] e_l = 0, e_r = 0;
   initial begin
      forever begin
         @(posedge i_clk);
         #2;
         if (chk_on && cyc < MAXC) begin
            e_v = 0; e_e = 0;
            if (ev[cyc].has) begin
               e_v = ev[cyc].valid; e_e = ev[cyc].err;
               e_lk = ev[cyc].lock; e_sl = ev[cyc].slot;
               if (e_v) begin e_l = ev[cyc].left; e_r = ev[cyc].right; end
            end
            check("valid", 32'(o_valid), 32'(e_v));
            check("left", 32'(o_left), 32'(e_l));
            check("right", 32'(o_right), 32'(e_r));
            check("slot_len", 32'(o_slot_len), 32'(e_sl));
            if (!loose) begin
               check("err", 32'(o_err), 32'(e_e));
               check("locked", 32'(o_locked), 32'(e_lk));
            end
         end
      end
   end

   initial begin
      int nl, nr, len, r, nerr;
      logic [31:0] lv, rv;

      // Reset held while inputs toggle
      repeat (20) begin
         @(negedge i_clk);
         i_bck = 1'($urandom); i_ws = 1'($urandom); i_data = 1'($urandom);
      end
      @(negedge i_clk);
      check("rst_left", 32'(o_left), 0);
      check("rst_right", 32'(o_right), 0);
      check("rst_valid", 32'(o_valid), 0);
      check("rst_locked", 32'(o_locked), 0);
      check("rst_slot", 32'(o_slot_len), 0);
      check("rst_err", 32'(o_err), 0);
      i_bck = 0; i_ws = 0; i_data = 0;
      repeat (4) @(negedge i_clk);
      reset_n = 1'b1;
      chk_on = 1;
      repeat (4) @(negedge i_clk);

      repeat (4) send_frame(16, 16, 32'h1234, 32'hABCD);
      settle();
      check("p16_left", 32'(o_left), 32'h1234);
      check("p16_right", 32'(o_right), 32'hABCD);
      check("p16_slot", 32'(o_slot_len), 16);
      check("p16_locked", 32'(o_locked), 1);

      repeat (4) send_frame(24, 24, 32'h89ABCD, 32'h123456);
      settle();
      check("p24_left", 32'(o_left), 32'h89AB);
      check("p24_right", 32'(o_right), 32'h1234);
      check("p24_slot", 32'(o_slot_len), 24);

      repeat (4) send_frame(12, 12, 32'hFFF, 32'h801);
      settle();
      check("p12_left", 32'(o_left), 32'hFFF0);
      check("p12_right", 32'(o_right), 32'h8010);
      check("p12_locked", 32'(o_locked), 1);

      repeat (3) send_frame(16, 16, 32'h1234, 32'hABCD);
      send_frame(17, 16, 32'h1234, 32'hABCD);
      settle();
      check("long_left_locked", 32'(o_locked), 0);
      repeat (2) send_frame(16, 16, 32'h1234, 32'hABCD);
      settle();
      check("relock", 32'(o_locked), 1);

      // Random data, occasional slot-length changes and malformed frames
      len = 16;
      repeat (20) begin
         r = $urandom_range(0, 9);
         if (r == 0) len = $urandom_range(8, 32);
         nl = len; nr = len;
         if (r == 1) nl = (len == 32) ? 31 : len + 1;
         if (r == 2) begin nl = $urandom_range(4, 7); nr = nl; end
         lv = $urandom & mask(nl);
         rv = $urandom & mask(nr);
         send_frame(nl, nr, lv, rv);
      end

      // Lock, then stop BCK past the timeout
      repeat (3) send_frame(16, 16, 32'h1234, 32'hABCD);
      loose = 1;
      while (cyc < last_hi + TIMEOUT - 6) @(negedge i_clk);
      check("pre_timeout_locked", 32'(o_locked), 1);
      nerr = 0;
      repeat (40) begin
         @(posedge i_clk); #2;
         if (o_err) nerr++;
      end
      check("timeout_locked", 32'(o_locked), 0);
      check("timeout_err_pulses", 32'(nerr), 1);
      chk_on = 0;

      // Asynchronous reset in the middle of a slot
      begin
         int hi;
         repeat (5) drive_bit(1'b0, 1'b1, hi);
      end
      @(negedge i_clk);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_left", 32'(o_left), 0);
      check("mid_rst_right", 32'(o_right), 0);
      check("mid_rst_slot", 32'(o_slot_len), 0);
      check("mid_rst_locked", 32'(o_locked), 0);
      check("mid_rst_valid", 32'(o_valid), 0);
      check("mid_rst_err", 32'(o_err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
